tick_gen_multi: RTL and testbench
=================================

// Module: tick_gen_multi
// PURPOSE
//  Parametrised multi-channel tick generator: one shared prescaler feeds NUM_CH
//  independent programmable dividers, each periodic or one-shot with start/stop.
//  Successor to the fixed two-stage divider; supplies baud/scan/debounce strobes
//  to UART, display and key blocks from a single instance on the system clock.
// PARAMETERS
//  PRE_DIV  10000  prescaler divide ratio (>=1); base_tick every PRE_DIV clk cycles
//  NUM_CH   4      number of independent channels (>=1)
//  CNT_W    16     channel period/counter width in bits
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  rst         in   1             asynchronous, active-high reset
//  ch_start    in   NUM_CH        per-channel 1-cycle start/restart strobe
//  ch_stop     in   NUM_CH        per-channel 1-cycle stop strobe
//  ch_oneshot  in   NUM_CH        mode sampled at start: 1=one-shot, 0=periodic
//  ch_period   in   NUM_CH*CNT_W  period in base_ticks, ch i at [i*CNT_W +: CNT_W]
//  base_tick   out  1             prescaler strobe, 1 cycle wide
//  ch_tick     out  NUM_CH        per-channel output strobe, 1 cycle wide, registered
//  ch_busy     out  NUM_CH        1 while channel in RUN
//  ch_wave     out  NUM_CH        square wave (only with TICK_GEN_SQUARE_EN)
// BEHAVIOUR
//  Reset: pre_cnt=0, all channels IDLE, cnt=0; base_tick, ch_tick, ch_busy, ch_wave=0.
//  Prescaler: pre_cnt 0..PRE_DIV-1, wraps to 0; base_tick = (pre_cnt==PRE_DIV-1).
//   First base_tick PRE_DIV-1 edges after reset release; PRE_DIV=1 -> constantly 1.
//  Channel FSM states IDLE, RUN; ch_busy = (state==RUN).
//  IDLE: ch_start with ch_period!=0 -> RUN; latch period_q, mode_q; cnt=0.
//   ch_start with ch_period==0 ignored, stays IDLE. ch_stop in IDLE: no effect.
//  RUN: on base_tick, if cnt==period_q-1 -> cnt=0, ch_tick=1 next cycle,
//   one-shot -> IDLE on same edge (ch_busy low in the cycle ch_tick is high);
//   else cnt=cnt+1. No base_tick -> cnt holds.
//  Periodic spacing between ch_tick pulses = period_q*PRE_DIV clk cycles exactly.
//  ch_start in RUN: restart (reload period_q/mode_q, cnt=0); no tick that cycle.
//  ch_stop in RUN: -> IDLE next edge, cnt=0, no tick even if terminal same cycle.
//  ch_start and ch_stop same cycle: stop wins.
//  ch_period/ch_oneshot changes during RUN ignored until next start.
//  Counters never exceed period_q-1; no overflow possible at CNT_W.
//  Reset mid-operation: immediate return to reset values, no residual tick.
// CONFIGURATION
//  TICK_GEN_SQUARE_EN defined: ch_wave port present; bit toggles on every ch_tick
//   of its channel (register toggles with the tick register); cleared to 0 on rst
//   and on ch_stop. One-shot leaves ch_wave at its toggled value.
//  Not defined: ch_wave port and toggle registers absent; all else identical.
// STRUCTURE
//  tick_gen_pkg: channel state enum {IDLE, RUN}, width helper constants.
//  Sub-module tick_gen_ch: one channel FSM+counter+tick register (+wave reg),
//   instantiated NUM_CH times in a generate loop; prescaler lives in top.
// TESTING (PRE_DIV=4, NUM_CH=2, CNT_W=8)
//  Free-run after reset -> base_tick high at cycles 3,7,11,...; never 2 in a row.
//  ch0 start, period=3, periodic -> ch_tick[0] every 12 cycles, ch_busy[0] stays 1.
//  ch1 start, period=2, one-shot -> exactly one ch_tick[1] after 2 base_ticks, busy
//   falls in tick cycle; ch0 unaffected throughout.
//  ch0 running, stop on terminal base_tick cycle -> no tick, busy 0 next cycle;
//   start+stop same cycle -> stays/returns IDLE.
//  start with period=0 -> no busy, no tick; restart mid-count -> next tick
//   period_q*PRE_DIV cycles after restart aligned to base_tick.
//  rst asserted mid-RUN -> all outputs 0 immediately; with TICK_GEN_SQUARE_EN,
//   ch_wave toggles per tick and clears on stop/reset.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_pkg
// Shared types and helpers for the multi-channel tick generator.
//   ch_state_t : channel FSM state (IDLE / RUN)
//   cnt_w_of() : counter width needed to hold 0..n-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    function automatic int cnt_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// ---------------------------------------------------------------------------
// tick_gen_ch
// One channel of the tick generator: IDLE/RUN FSM, base_tick counter and the
// registered output strobe. Optional square-wave register (TICK_GEN_SQUARE_EN).
// Ports:
//   clk, rst     : clock, async active-high reset
//   i_base_tick  : prescaler strobe, advances the counter while running
//   i_start      : start/restart strobe (ignored when i_period == 0)
//   i_stop       : stop strobe, dominates i_start
//   i_oneshot    : mode latched at start (1 = one-shot)
//   i_period     : period in base_ticks, latched at start
//   o_tick       : 1-cycle strobe, registered
//   o_busy       : high while in RUN
//   o_wave       : toggles on each tick, cleared on stop (macro only)
// ---------------------------------------------------------------------------
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_base_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_oneshot,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick,
    output logic             o_busy
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic             o_wave
`endif
);

    ch_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_q;
    logic             r_mode_q;
    logic             r_tick;
    logic             w_load;
    logic             w_term;
`ifdef TICK_GEN_SQUARE_EN
    logic             r_wave;
`endif

    // A zero period would never terminate, so such a start is dropped.
    assign w_load = i_start && (i_period != '0);
    // period_q is never 0 in RUN, so period_q-1 cannot underflow.
    assign w_term = (r_cnt == r_period_q - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period_q <= '0;
            r_mode_q   <= 1'b0;
            r_tick     <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
            r_wave     <= 1'b0;
`endif
        end else begin
            r_tick <= 1'b0;
            if (i_stop) begin
                // Stop dominates start and suppresses a coincident terminal tick.
                r_state <= IDLE;
                r_cnt   <= '0;
`ifdef TICK_GEN_SQUARE_EN
                r_wave  <= 1'b0;
`endif
            end else if (w_load) begin
                r_state    <= RUN;
                r_cnt      <= '0;
                r_period_q <= i_period;
                r_mode_q   <= i_oneshot;
            end else if (r_state == RUN && i_base_tick) begin
                if (w_term) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
`ifdef TICK_GEN_SQUARE_EN
                    r_wave <= ~r_wave;
`endif
                    // One-shot leaves RUN on the same edge that raises the tick.
                    if (r_mode_q)
                        r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_busy = (r_state == RUN);
`ifdef TICK_GEN_SQUARE_EN
    assign o_wave = r_wave;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
// Shared prescaler feeding NUM_CH independent programmable tick channels.
// Optional feature macro: TICK_GEN_SQUARE_EN adds the ch_wave square outputs.
// Ports:
//   clk, rst   : clock, async active-high reset
//   ch_start   : per-channel start/restart strobe
//   ch_stop    : per-channel stop strobe (wins over start)
//   ch_oneshot : per-channel mode, sampled at start
//   ch_period  : per-channel period in base_ticks, ch i at [i*CNT_W +: CNT_W]
//   base_tick  : prescaler strobe, every PRE_DIV cycles
//   ch_tick    : per-channel registered 1-cycle strobe
//   ch_busy    : per-channel RUN indicator
//   ch_wave    : per-channel square wave (macro only)
// ---------------------------------------------------------------------------
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int PRE_DIV = 10000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_oneshot,
    input  logic [NUM_CH*CNT_W-1:0] ch_period,
    output logic                    base_tick,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_busy
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]       ch_wave
`endif
);

    localparam int               PRE_W    = cnt_w_of(PRE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_base_tick;

    // With PRE_DIV == 1 the counter sits at 0 == PRE_LAST, so base_tick is constant 1.
    assign w_base_tick = (r_pre_cnt == PRE_LAST);
    assign base_tick   = w_base_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pre_cnt <= '0;
        else if (w_base_tick)
            r_pre_cnt <= '0;
        else
            r_pre_cnt <= r_pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_base_tick (w_base_tick),
            .i_start     (ch_start[i]),
            .i_stop      (ch_stop[i]),
            .i_oneshot   (ch_oneshot[i]),
            .i_period    (ch_period[i*CNT_W +: CNT_W]),
            .o_tick      (ch_tick[i]),
            .o_busy      (ch_busy[i])
`ifdef TICK_GEN_SQUARE_EN
            ,
            .o_wave      (ch_wave[i])
`endif
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_start = '0;
    logic [1:0]  ch_stop = '0;
    logic [1:0]  ch_oneshot = '0;
    logic [15:0] ch_period = '0;
    logic        base_tick;
    logic [1:0]  ch_tick;
    logic [1:0]  ch_busy;
`ifdef TICK_GEN_SQUARE_EN
    logic [1:0]  ch_wave;
`endif

    int total = 0;
    int bad = 0;
    int k = 0;   // edges since reset release

    always #5 clk = ~clk;

    tick_gen_multi #(.PRE_DIV(4), .NUM_CH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_start   (ch_start),
        .ch_stop    (ch_stop),
        .ch_oneshot (ch_oneshot),
        .ch_period  (ch_period),
        .base_tick  (base_tick),
        .ch_tick    (ch_tick),
        .ch_busy    (ch_busy)
`ifdef TICK_GEN_SQUARE_EN
        ,
        .ch_wave    (ch_wave)
`endif
    );

    typedef struct {
        logic [1:0] st, sp, os;
        logic [7:0] p0, p1;
        logic       eb;
        logic [1:0] et, ebz, ew;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t row(input logic [1:0] st, sp, os, input logic [7:0] p0, p1,
                                 input logic eb, input logic [1:0] et, ebz, ew);
        vec_t v;
        v.st = st; v.sp = sp; v.os = os; v.p0 = p0; v.p1 = p1;
        v.eb = eb; v.et = et; v.ebz = ebz; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", nm, k, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic [1:0] st, sp, os, input logic [7:0] p0, p1);
        ch_start = st; ch_stop = sp; ch_oneshot = os; ch_period = {p1, p0};
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        int got;
        // k:  1     2 ...; base expected at k%4==3; ch0 per=3 periodic, ch1 per=2 one-shot
        tbl[0]  = row(2'b11, 0, 2'b10, 3, 2, 0, 2'b00, 2'b11, 2'b00);
        tbl[1]  = row(0, 0, 2'b10, 3, 2, 0, 2'b00, 2'b11, 2'b00);
        tbl[2]  = row(0, 0, 2'b10, 3, 2, 1, 2'b00, 2'b11, 2'b00);
        tbl[3]  = row(0, 0, 2'b10, 3, 2, 0, 2'b00, 2'b11, 2'b00);
        tbl[4]  = row(0, 0, 2'b10, 3, 2, 0, 2'b00, 2'b11, 2'b00);
        tbl[5]  = row(0, 0, 2'b10, 3, 2, 0, 2'b00, 2'b11, 2'b00);
        tbl[6]  = row(0, 0, 2'b10, 3, 2, 1, 2'b00, 2'b11, 2'b00);
        tbl[7]  = row(0, 0, 2'b10, 3, 2, 0, 2'b10, 2'b01, 2'b10);
        tbl[8]  = row(0, 0, 2'b10, 3, 2, 0, 2'b00, 2'b01, 2'b10);
        // period/mode inputs change mid-run: must be ignored
        tbl[9]  = row(0, 0, 2'b11, 5, 2, 0, 2'b00, 2'b01, 2'b10);
        tbl[10] = row(0, 0, 2'b11, 5, 2, 1, 2'b00, 2'b01, 2'b10);
        tbl[11] = row(0, 0, 2'b11, 5, 2, 0, 2'b01, 2'b01, 2'b11);
        for (int i = 12; i < 23; i++)
            tbl[i] = row(0, 0, 2'b11, 5, 2, ((i + 1) % 4 == 3), 2'b00, 2'b01, 2'b11);
        tbl[23] = row(0, 0, 2'b11, 5, 2, 0, 2'b01, 2'b01, 2'b10);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_base", base_tick, 0);
        chk("rst_tick", ch_tick, 0);
        chk("rst_busy", ch_busy, 0);
`ifdef TICK_GEN_SQUARE_EN
        chk("rst_wave", ch_wave, 0);
`endif
        rst = 1'b0;
        k = 0;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].os, tbl[i].p0, tbl[i].p1);
            chk("tbl_base", base_tick, tbl[i].eb);
            chk("tbl_tick", ch_tick, tbl[i].et);
            chk("tbl_busy", ch_busy, tbl[i].ebz);
`ifdef TICK_GEN_SQUARE_EN
            chk("tbl_wave", ch_wave, tbl[i].ew);
`endif
        end

        // stop on the terminal base_tick cycle of ch0 (edge 36)
        repeat (11) step(0, 0, 0, 5, 2);
        step(0, 2'b01, 0, 5, 2);
        chk("stop_term_tick", ch_tick, 0);
        chk("stop_term_busy", ch_busy, 0);
        step(0, 0, 0, 5, 2);
        chk("stop_after_tick", ch_tick, 0);

        // start then start+stop while running, then start+stop while idle
        step(2'b01, 0, 0, 1, 2);
        chk("start_busy", ch_busy, 2'b01);
        step(2'b01, 2'b01, 0, 1, 2);
        chk("startstop_run_busy", ch_busy, 0);
        step(2'b01, 2'b01, 0, 1, 2);
        chk("startstop_idle_busy", ch_busy, 0);

        // start with zero period is ignored
        step(2'b10, 0, 0, 1, 0);
        chk("zero_per_busy", ch_busy, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0);
            chk("zero_per_tick", ch_tick, 0);
        end

        // restart mid-count: start at 50, restart at 53 -> tick at 60
        step(2'b01, 0, 0, 2, 0);
        step(0, 0, 0, 2, 0);
        step(0, 0, 0, 2, 0);
        step(2'b01, 0, 0, 2, 0);
        got = -1;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 2, 0);
            if (ch_tick[0]) begin
                got = k;
                break;
            end
        end
        chk("restart_tick_k", got, 60);
`ifdef TICK_GEN_SQUARE_EN
        chk("wave_restart", ch_wave, 2'b11);
`endif
        step(0, 2'b01, 0, 2, 0);
        chk("stop2_busy", ch_busy, 0);
`ifdef TICK_GEN_SQUARE_EN
        chk("wave_stop_clr", ch_wave, 2'b10);
`endif

        // reset asserted mid-RUN, in the cycle ch_tick is high
        step(2'b01, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("pre_rst_tick", ch_tick, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_tick", ch_tick, 0);
        chk("mid_rst_busy", ch_busy, 0);
        chk("mid_rst_base", base_tick, 0);
`ifdef TICK_GEN_SQUARE_EN
        chk("mid_rst_wave", ch_wave, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        step(0, 0, 0, 1, 0);
        chk("post_rst_base1", base_tick, 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_base2", base_tick, 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_base3", base_tick, 1);
        chk("post_rst_busy", ch_busy, 0);
        chk("post_rst_tick", ch_tick, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
